// File: rtl/riscv_data_mem_sys.sv
// M-stage data memory: byte-enabled RAM, sign/zero-extending loads, programmable wait states,
// misalignment flagging, and two MMIO words (GPIO register, free-running cycle counter).
module riscv_data_mem_sys #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_FFF0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        stall_o,
  output logic [31:0] rdata_o,
  output logic        done_o,
  output logic        misaligned_o,
  output logic [31:0] gpio_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);

  typedef enum logic {S_IDLE, S_WAIT} state_t;

  state_t      state;
  logic [3:0]  cnt;
  logic        l_we;
  logic [2:0]  l_funct3;
  logic [31:0] l_addr;
  logic [31:0] l_wdata;
  logic [31:0] cycle;
  logic [31:0] mem [DEPTH_WORDS];

  logic        in_wait, accept, fire, bad, commit;
  logic        a_we, is_gpio, is_cyc;
  logic [2:0]  a_f3;
  logic [31:0] a_addr, a_wdata, src, ext, lane;
  logic [15:0] sh;
  logic [3:0]  be;
  logic [AW-1:0] idx;

  // In WAIT the latched request drives every datapath decision.
  always_comb begin
    in_wait = (state == S_WAIT);
    a_we    = in_wait ? l_we     : req_we;
    a_f3    = in_wait ? l_funct3 : req_funct3;
    a_addr  = in_wait ? l_addr   : req_addr;
    a_wdata = in_wait ? l_wdata  : req_wdata;
    accept  = (state == S_IDLE) && req_valid;
    fire    = reset && ((accept && (WAIT_STATES == 0)) || (in_wait && cnt == 4'd1));
    stall_o = reset && ((accept && (WAIT_STATES != 0)) || (in_wait && cnt != 4'd1));

    bad = (a_f3[1:0] == 2'b11) || (a_f3[2:1] == 2'b11) ||
          ((a_f3[1:0] == 2'b01) && a_addr[0]) ||
          ((a_f3[1:0] == 2'b10) && (a_addr[1:0] != 2'b00));

    is_gpio = (a_addr[31:2] == MMIO_BASE[31:2]);
    is_cyc  = (a_addr[31:2] == (MMIO_BASE[31:2] + 30'd1));
    idx     = a_addr[AW+1:2];

    if (is_gpio)     src = gpio_o;
    else if (is_cyc) src = cycle;
    else             src = mem[idx];

    sh = 16'(src >> {a_addr[1:0], 3'b000});
    case (a_f3)
      3'b000:  ext = {{24{sh[7]}}, sh[7:0]};
      3'b001:  ext = {{16{sh[15]}}, sh};
      3'b010:  ext = src;
      3'b100:  ext = {24'd0, sh[7:0]};
      3'b101:  ext = {16'd0, sh};
      default: ext = '0;
    endcase

    case (a_f3[1:0])
      2'b00:   begin be = 4'b0001 << a_addr[1:0];               lane = {4{a_wdata[7:0]}};  end
      2'b01:   begin be = a_addr[1] ? 4'b1100 : 4'b0011;         lane = {2{a_wdata[15:0]}}; end
      default: begin be = 4'b1111;                               lane = a_wdata;            end
    endcase

    commit       = fire && a_we && !bad;
    done_o       = fire;
    misaligned_o = fire && bad;
    rdata_o      = (fire && !a_we && !bad) ? ext : '0;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= S_IDLE;
      cnt      <= '0;
      l_we     <= 1'b0;
      l_funct3 <= '0;
      l_addr   <= '0;
      l_wdata  <= '0;
    end else begin
      case (state)
        S_IDLE: if (req_valid && (WAIT_STATES != 0)) begin
          l_we     <= req_we;
          l_funct3 <= req_funct3;
          l_addr   <= req_addr;
          l_wdata  <= req_wdata;
          cnt      <= WAIT_STATES[3:0];
          state    <= S_WAIT;
        end
        S_WAIT: if (cnt == 4'd1) begin
          cnt   <= '0;
          state <= S_IDLE;
        end else begin
          cnt <= cnt - 4'd1;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_o <= '0;
      cycle  <= '0;
    end else begin
      cycle <= cycle + 32'd1;
      if (commit && is_gpio)
        for (int unsigned i = 0; i < 4; i++)
          if (be[i]) gpio_o[i*8 +: 8] <= lane[i*8 +: 8];
    end
  end

  always_ff @(posedge clk) begin
    if (commit && !is_gpio && !is_cyc)
      for (int unsigned i = 0; i < 4; i++)
        if (be[i]) mem[idx][i*8 +: 8] <= lane[i*8 +: 8];
  end

endmodule

// File: tb/tb_riscv_data_mem_sys.sv
// Bench for riscv_data_mem_sys: a zero-wait and a 3-wait instance, directed cases plus random
// traffic checked against a byte-array memory model.
module tb_riscv_data_mem_sys;

  localparam logic [31:0] MB = 32'hFFFF_FFF0;
  localparam int NB = 64;  // bytes in each 16-word RAM

  logic        clk = 0;
  logic        rst_n = 0;
  logic        v[2], we[2], st[2], dn[2], ms[2];
  logic [2:0]  f3[2];
  logic [31:0] ad[2], wd[2], rd[2], gp[2];

  int tests = 0;
  int fails = 0;
  int ws[2] = '{0, 3};

  logic [7:0]  m[2][NB];
  logic [31:0] mg[2];

  always #5 clk = ~clk;

  riscv_data_mem_sys #(.DEPTH_WORDS(16), .WAIT_STATES(0), .MMIO_BASE(MB)) dut0 (
    .clk(clk), .reset(rst_n), .req_valid(v[0]), .req_we(we[0]), .req_funct3(f3[0]),
    .req_addr(ad[0]), .req_wdata(wd[0]), .stall_o(st[0]), .rdata_o(rd[0]), .done_o(dn[0]),
    .misaligned_o(ms[0]), .gpio_o(gp[0]));

  riscv_data_mem_sys #(.DEPTH_WORDS(16), .WAIT_STATES(3), .MMIO_BASE(MB)) dut1 (
    .clk(clk), .reset(rst_n), .req_valid(v[1]), .req_we(we[1]), .req_funct3(f3[1]),
    .req_addr(ad[1]), .req_wdata(wd[1]), .stall_o(st[1]), .rdata_o(rd[1]), .done_o(dn[1]),
    .misaligned_o(ms[1]), .gpio_o(gp[1]));

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic bit is_bad(logic [2:0] f, logic [31:0] a);
    return (f == 3) || (f == 6) || (f == 7) ||
           (((f == 1) || (f == 5)) && (a % 2 != 0)) || ((f == 2) && (a % 4 != 0));
  endfunction

  function automatic logic [7:0] byte_at(int i, logic [31:0] a, int k);
    if (a[31:2] == MB[31:2]) return 8'((mg[i] >> (8 * k)) & 32'hFF);
    return m[i][((a % NB) / 4) * 4 + k];
  endfunction

  function automatic logic [31:0] ref_load(int i, logic [2:0] f, logic [31:0] a);
    int k = a % 4;
    logic [31:0] b, h;
    if (is_bad(f, a)) return 0;
    b = byte_at(i, a, k);
    h = b + 256 * byte_at(i, a, (k + 1) % 4);
    case (f)
      0: return (b > 127) ? (b | 32'hFFFF_FF00) : b;
      1: return (h > 32767) ? (h | 32'hFFFF_0000) : h;
      4: return b;
      5: return h;
      default: return byte_at(i, a, 0) + 256 * byte_at(i, a, 1) +
                      65536 * byte_at(i, a, 2) + 16777216 * byte_at(i, a, 3);
    endcase
  endfunction

  task automatic ref_store(int i, logic [2:0] f, logic [31:0] a, logic [31:0] d);
    int k = a % 4;
    int n = (f[1:0] == 0) ? 1 : (f[1:0] == 1) ? 2 : 4;
    if (is_bad(f, a) || a[31:2] == MB[31:2] + 1) return;
    for (int j = 0; j < n; j++) begin
      logic [7:0] bv = 8'((d >> (8 * j)) & 32'hFF);
      int p = (n == 4) ? j : k + j;
      if (a[31:2] == MB[31:2])
        mg[i] = (mg[i] & ~(32'hFF << (8 * p))) | (32'(bv) << (8 * p));
      else
        m[i][((a % NB) / 4) * 4 + p] = bv;
    end
  endtask

  // Drive one request; return data, flag and number of stalled cycles seen before done.
  task automatic access(int i, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] d,
                        output logic [31:0] r, output logic mis, output int stalls);
    bit got = 0;
    stalls = 0;
    r = 'x;
    mis = 'x;
    @(negedge clk);
    v[i] = 1; we[i] = w; f3[i] = f; ad[i] = a; wd[i] = d;
    for (int c = 0; c < 40 && !got; c++) begin
      #1;
      if (dn[i]) begin
        got = 1; r = rd[i]; mis = ms[i];
        if (st[i]) stalls = 99;
        @(posedge clk); #1;
        v[i] = 0;
      end else begin
        if (st[i]) stalls++;
        @(negedge clk);
        v[i] = 0;
      end
    end
    if (!got) begin
      v[i] = 0;
      chk("timeout", 32'd0, 32'd1);
    end
  endtask

  task automatic run(int i, logic w, logic [2:0] f, logic [31:0] a, logic [31:0] d, string tag);
    logic [31:0] r, exp;
    logic mis;
    int s;
    exp = ref_load(i, f, a);
    access(i, w, f, a, d, r, mis, s);
    if (w) ref_store(i, f, a, d);
    else chk({tag, ".rdata"}, r, exp);
    chk({tag, ".mis"}, 32'(mis), 32'(is_bad(f, a)));
    chk({tag, ".stalls"}, s, ws[i]);
  endtask

  initial begin
    logic [31:0] r, c1, c2;
    logic mis;
    int s;
    for (int i = 0; i < 2; i++) begin
      v[i] = 0; we[i] = 0; f3[i] = 0; ad[i] = 0; wd[i] = 0; mg[i] = 0;
    end
    v[0] = 1; we[0] = 1; f3[0] = 3'd2; ad[0] = 32'h10;
    repeat (2) @(negedge clk);
    chk("rst.done", 32'(dn[0]), 0);
    chk("rst.stall", 32'(st[0]), 0);
    chk("rst.rdata", rd[0], 0);
    chk("rst.gpio", gp[0], 0);
    v[0] = 0;
    rst_n = 1;

    for (int i = 0; i < 2; i++)
      for (int w = 0; w < 16; w++) run(i, 1, 3'd2, w * 4, $urandom, "init");

    // zero-wait word store/load, byte store and extending loads
    run(0, 1, 3'd2, 32'h10, 32'hDEADBEEF, "t1.sw");
    run(0, 0, 3'd2, 32'h10, 0, "t1.lw");
    chk("t1.val", ref_load(0, 3'd2, 32'h10), 32'hDEADBEEF);
    run(0, 1, 3'd0, 32'h13, 32'h80, "t2.sb");
    run(0, 0, 3'd0, 32'h13, 0, "t2.lb");
    run(0, 0, 3'd4, 32'h13, 0, "t2.lbu");
    run(0, 0, 3'd2, 32'h10, 0, "t2.lw");
    run(0, 0, 3'd2, 32'h50, 0, "wrap.lw");

    // wait states: back-to-back loads
    run(1, 0, 3'd2, 32'h8, 0, "t3.lw0");
    run(1, 0, 3'd2, 32'hC, 0, "t3.lw1");

    // misalignment on both instances
    for (int i = 0; i < 2; i++) begin
      run(i, 1, 3'd2, 32'h12, 32'h11223344, "t4.sw");
      run(i, 0, 3'd1, 32'h11, 0, "t4.lh");
      run(i, 0, 3'd2, 32'h10, 0, "t4.chk");
      run(i, 1, 3'd7, 32'h14, 32'hFFFF, "t4.ill");
      run(i, 0, 3'd2, 32'h14, 0, "t4.chk2");
    end

    // GPIO and cycle counter
    run(0, 1, 3'd2, MB, 32'h5, "t5.gpio");
    chk("t5.gpio_o", gp[0], 32'h5);
    run(0, 1, 3'd0, MB + 2, 32'hA7, "t5.gsb");
    chk("t5.gpio_b", gp[0], mg[0]);
    run(0, 0, 3'd0, MB + 2, 0, "t5.glb");
    access(0, 0, 3'd2, MB + 4, 0, c1, mis, s);
    repeat (9) @(posedge clk);
    access(0, 0, 3'd2, MB + 4, 0, c2, mis, s);
    chk("t5.cycle", c2 - c1, 10);
    run(0, 1, 3'd2, MB + 4, 32'h0, "t5.cyc_st");
    access(0, 0, 3'd2, MB + 4, 0, c1, mis, s);
    chk("t5.cyc_ro", 32'(c1 > 32'd100), 1);

    // random traffic
    for (int n = 0; n < 120; n++) begin
      int i = n % 2;
      logic w = 1'($urandom_range(0, 1));
      logic [2:0] f;
      logic [31:0] a = $urandom & 32'h0FFF_FFFF;
      int sel = $urandom_range(0, 9);
      if (w) f = (sel == 9) ? 3'd3 : 3'(sel % 3);
      else   f = (sel == 9) ? 3'd6 : (sel < 3) ? 3'(sel) : 3'(4 + sel % 2);
      if ($urandom_range(0, 7) == 0) a = MB + $urandom_range(0, 3);
      run(i, w, f, a, $urandom, "rnd");
    end

    // reset in the 2nd stall cycle of a store
    run(1, 1, 3'd2, MB, 32'hCAFE, "t6.gpio");
    @(negedge clk);
    v[1] = 1; we[1] = 1; f3[1] = 3'd2; ad[1] = 32'h20; wd[1] = 32'h12345678;
    #1 chk("t6.stall1", 32'(st[1]), 1);
    @(negedge clk);
    #1 chk("t6.stall2", 32'(st[1]), 1);
    rst_n = 0;
    #1;
    chk("t6.r_stall", 32'(st[1]), 0);
    chk("t6.r_done", 32'(dn[1]), 0);
    chk("t6.r_rdata", rd[1], 0);
    chk("t6.r_gpio", gp[1], 0);
    v[1] = 0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1;
    mg[0] = 0;
    mg[1] = 0;
    run(1, 0, 3'd2, 32'h20, 0, "t6.ram");
    run(1, 0, 3'd2, MB, 0, "t6.gpio_ld");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
